tm_display_scheduler: RTL and testbench



---
 rtl/tm_display_scheduler.sv | 263 ++++++++++++++++++++++++++
 tb/tb_tm_display_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm_display_scheduler.sv
// Feeds the two-wire 7-segment writer from a 16-byte framebuffer: control command first, then dirty digits in ascending order.
// Optional periodic full refresh is enabled by defining AUTO_REFRESH_EN.
module tm_display_scheduler #(
    parameter int GAP_CYCLES     = 12000,
    parameter int ACK_TIMEOUT    = 64
`ifdef AUTO_REFRESH_EN
    ,
    parameter int REFRESH_CYCLES = 12000000
`endif
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       disp_on,
    input  logic [2:0] bright,
    output logic       wp_valid,
    output logic [7:0] wp_pos,
    output logic [7:0] wp_value,
    input  logic       wp_busy,
    output logic       idle,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] ACK_LAST = 32'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  fb_q [16];
    logic [7:0]  fb_d [16];
    logic [15:0] dirty_q, dirty_d;
    logic        ctrl_pending_q, ctrl_pending_d;
    logic [3:0]  ctrl_in_q;
    logic [3:0]  ctrl_sent_q, ctrl_sent_d;
    logic        sel_ctrl_q, sel_ctrl_d;
    logic [3:0]  sel_idx_q, sel_idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic        wp_valid_q, wp_valid_d;
    logic [7:0]  wp_pos_q, wp_pos_d;
    logic [7:0]  wp_value_q, wp_value_d;
    logic        idle_q, idle_d;
    logic        err_q, err_d;

    logic        work_s;
    logic        issue_s;
    logic        timeout_s;
    logic [3:0]  issue_idx_s;
    logic        refresh_wrap_s;

    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            idx = m[i] ? 4'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [7:0] ctrl_byte(input logic [3:0] c);
        return c[3] ? (8'h88 | {5'b00000, c[2:0]}) : 8'h80;
    endfunction

    assign work_s      = ctrl_pending_q || (dirty_q != 16'h0000);
    assign issue_s     = (state_q == S_ISSUE) && !wp_busy && work_s;
    assign timeout_s   = (state_q == S_WAIT_ACK) && !wp_busy && (cnt_q == ACK_LAST);
    // Selection happens in ISSUE so writes that land while leaving IDLE still get ascending order.
    assign issue_idx_s = lowest_set(dirty_q);

`ifdef AUTO_REFRESH_EN
    localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYCLES - 1);
    logic [31:0] refresh_q, refresh_d;

    // Free-running refresh period counter.
    always_comb begin
        if (refresh_q == REFRESH_LAST) begin
            refresh_d = 32'd0;
        end else begin
            refresh_d = refresh_q + 32'd1;
        end
    end

    assign refresh_wrap_s = (refresh_q == REFRESH_LAST);

    // Refresh counter register.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            refresh_q <= 32'd0;
        end else begin
            refresh_q <= refresh_d;
        end
    end
`else
    assign refresh_wrap_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (work_s) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (!work_s) begin
                    state_d = S_IDLE;
                end else if (!wp_busy) begin
                    state_d = S_WAIT_ACK;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT_ACK: begin
                if (wp_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_DONE: begin
                if (!wp_busy) begin
                    state_d = sel_ctrl_q ? S_GAP : S_IDLE;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GAP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and bookkeeping; later assignments take priority, so host writes win.
    always_comb begin
        fb_d           = fb_q;
        dirty_d        = dirty_q;
        ctrl_pending_d = ctrl_pending_q | (ctrl_in_q != ctrl_sent_q);
        ctrl_sent_d    = ctrl_sent_q;
        sel_ctrl_d     = sel_ctrl_q;
        sel_idx_d      = sel_idx_q;
        wp_valid_d     = issue_s;
        wp_pos_d       = wp_pos_q;
        wp_value_d     = wp_value_q;
        err_d          = err_q | timeout_s;

        case (state_q)
            S_WAIT_ACK: cnt_d = cnt_q + 32'd1;
            S_GAP:      cnt_d = cnt_q + 32'd1;
            default:    cnt_d = 32'd0;
        endcase

        if (issue_s) begin
            sel_ctrl_d = ctrl_pending_q;
            sel_idx_d  = issue_idx_s;
            if (ctrl_pending_q) begin
                ctrl_pending_d = 1'b0;
                ctrl_sent_d    = ctrl_in_q;
                wp_pos_d       = 8'hFF;
                wp_value_d     = ctrl_byte(ctrl_in_q);
            end else begin
                dirty_d[issue_idx_s] = 1'b0;
                wp_pos_d             = {4'hC, issue_idx_s};
                wp_value_d           = fb_q[issue_idx_s];
            end
        end else begin
            sel_ctrl_d = sel_ctrl_q;
        end

        if (timeout_s) begin
            if (sel_ctrl_q) begin
                ctrl_pending_d = 1'b1;
            end else begin
                dirty_d[sel_idx_q] = 1'b1;
            end
        end else begin
            err_d = err_d;
        end

        if (refresh_wrap_s) begin
            dirty_d        = 16'hFFFF;
            ctrl_pending_d = 1'b1;
        end else begin
            dirty_d = dirty_d;
        end

        if (wr_en) begin
            fb_d[wr_addr]    = wr_data;
            dirty_d[wr_addr] = 1'b1;
        end else begin
            fb_d = fb_d;
        end

        idle_d = (state_d == S_IDLE) && !ctrl_pending_d && (dirty_d == 16'h0000);
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            fb_q           <= '{default: 8'h00};
            dirty_q        <= 16'hFFFF;
            ctrl_pending_q <= 1'b1;
            ctrl_in_q      <= 4'h0;
            ctrl_sent_q    <= 4'h0;
            sel_ctrl_q     <= 1'b0;
            sel_idx_q      <= 4'h0;
            cnt_q          <= 32'd0;
            wp_valid_q     <= 1'b0;
            wp_pos_q       <= 8'h00;
            wp_value_q     <= 8'h00;
            idle_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            fb_q           <= fb_d;
            dirty_q        <= dirty_d;
            ctrl_pending_q <= ctrl_pending_d;
            ctrl_in_q      <= {disp_on, bright};
            ctrl_sent_q    <= ctrl_sent_d;
            sel_ctrl_q     <= sel_ctrl_d;
            sel_idx_q      <= sel_idx_d;
            cnt_q          <= cnt_d;
            wp_valid_q     <= wp_valid_d;
            wp_pos_q       <= wp_pos_d;
            wp_value_q     <= wp_value_d;
            idle_q         <= idle_d;
            err_q          <= err_d;
        end
    end

    assign wp_valid = wp_valid_q;
    assign wp_pos   = wp_pos_q;
    assign wp_value = wp_value_q;
    assign idle     = idle_q;
    assign err      = err_q;

endmodule

// File: tb/tb_tm_display_scheduler.sv
// Directed bench for tm_display_scheduler with a simple busy-for-20-cycles writer model.
module tb_tm_display_scheduler;

`ifdef AUTO_REFRESH_EN
    localparam int TB_GAP = 100;
`else
    localparam int TB_GAP = 12000;
`endif

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'h0;
    logic [7:0] wr_data = 8'h00;
    logic       disp_on = 1'b1;
    logic [2:0] bright = 3'd1;
    logic       wp_valid;
    logic [7:0] wp_pos;
    logic [7:0] wp_value;
    logic       wp_busy = 1'b0;
    logic       idle;
    logic       err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int wmode = 1;
    int busy_cnt = 0;
    logic [7:0] log_pos[$];
    logic [7:0] log_val[$];
    int         log_cyc[$];

    always #5 CLK = ~CLK;

`ifdef AUTO_REFRESH_EN
    tm_display_scheduler #(.GAP_CYCLES(TB_GAP), .ACK_TIMEOUT(64), .REFRESH_CYCLES(2000)) dut (
`else
    tm_display_scheduler #(.GAP_CYCLES(TB_GAP), .ACK_TIMEOUT(64)) dut (
`endif
        .CLK(CLK), .RSTN(RSTN), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .disp_on(disp_on), .bright(bright), .wp_valid(wp_valid), .wp_pos(wp_pos),
        .wp_value(wp_value), .wp_busy(wp_busy), .idle(idle), .err(err)
    );

    // Pulse logger and writer model: busy for 20 cycles per accepted byte.
    always @(posedge CLK) begin
        #1;
        cyc = cyc + 1;
        if (wp_valid === 1'b1) begin
            log_pos.push_back(wp_pos);
            log_val.push_back(wp_value);
            log_cyc.push_back(cyc);
            if (wmode != 0) begin
                wp_busy  = 1'b1;
                busy_cnt = 20;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) wp_busy = 1'b0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_log();
        log_pos.delete();
        log_val.delete();
        log_cyc.delete();
    endtask

    task automatic wait_pulses(input int n, input int bound, input string what);
        int k = 0;
        while (log_pos.size() < n && k < bound) begin
            tick();
            k++;
        end
        n_chk++;
        if (log_pos.size() < n) begin
            n_fail++;
            $display("FAIL %s_wait: got %0d pulses, expected %0d", what, log_pos.size(), n);
        end
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (idle !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        int k = 0;
        int c0;
        RSTN = 1'b0; disp_on = 1'b1; bright = 3'd1; wmode = 1;
        repeat (3) tick();
        n_chk++; if (wp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", wp_valid); end
        n_chk++; if (wp_pos !== 8'h00) begin n_fail++; $display("FAIL rst_pos: got %h expected 00", wp_pos); end
        n_chk++; if (wp_value !== 8'h00) begin n_fail++; $display("FAIL rst_value: got %h expected 00", wp_value); end
        n_chk++; if (idle !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got %0b expected 0", idle); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b expected 0", err); end
        clear_log();
        RSTN = 1'b1;
        wait_pulses(1, 20, "boot_ctrl");
        n_chk++;
        if (log_pos[0] !== 8'hFF || log_val[0] !== 8'h89) begin
            n_fail++; $display("FAIL boot_ctrl: got %h/%h expected FF/89", log_pos[0], log_val[0]);
        end
        while (wp_busy !== 1'b1 && k < 50) begin tick(); k++; end
        while (wp_busy !== 1'b0 && k < 100) begin tick(); k++; end
        c0 = cyc;
        wait_pulses(2, TB_GAP + 100, "boot_gap");
        n_chk++;
        if (log_cyc[1] - c0 < TB_GAP || log_cyc[1] - c0 > TB_GAP + 5) begin
            n_fail++; $display("FAIL boot_gap: got %0d cycles expected %0d..%0d", log_cyc[1] - c0, TB_GAP, TB_GAP + 5);
        end
        wait_pulses(17, 1000, "boot_digits");
        for (int i = 0; i < 16; i++) begin
            n_chk++;
            if (log_pos[i + 1] !== (8'hC0 + 8'(i)) || log_val[i + 1] !== 8'h00) begin
                n_fail++; $display("FAIL boot_digit%0d: got %h/%h expected %h/00", i, log_pos[i + 1], log_val[i + 1], 8'hC0 + 8'(i));
            end
        end
        wait_idle(100);
        n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL boot_idle: got %0b expected 1", idle); end
    endtask

    task automatic test_single_write();
        clear_log();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h4F;
        tick();
        wr_en = 1'b0;
        n_chk++; if (wp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_lat1: got %0b expected 0", wp_valid); end
        tick();
        n_chk++; if (wp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_lat2: got %0b expected 0", wp_valid); end
        tick();
        n_chk++;
        if (wp_valid !== 1'b1 || wp_pos !== 8'hC3 || wp_value !== 8'h4F) begin
            n_fail++; $display("FAIL wr_lat3: got %0b %h/%h expected 1 C3/4F", wp_valid, wp_pos, wp_value);
        end
        wait_idle(100);
        n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL wr_idle: got %0b expected 1", idle); end
        n_chk++; if (log_pos.size() != 1) begin n_fail++; $display("FAIL wr_count: got %0d expected 1", log_pos.size()); end
    endtask

    task automatic test_order_ctrl();
        clear_log();
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h81;
        tick();
        wr_addr = 4'd2; wr_data = 8'h5B;
        tick();
        wr_en = 1'b0;
        wait_pulses(1, 20, "order_first");
        n_chk++;
        if (log_pos[0] !== 8'hC2 || log_val[0] !== 8'h5B) begin
            n_fail++; $display("FAIL order_first: got %h/%h expected C2/5B", log_pos[0], log_val[0]);
        end
        bright = 3'd7;
        wait_pulses(3, TB_GAP + 500, "order_rest");
        n_chk++;
        if (log_pos[1] !== 8'hFF || log_val[1] !== 8'h8F) begin
            n_fail++; $display("FAIL order_ctrl: got %h/%h expected FF/8F", log_pos[1], log_val[1]);
        end
        n_chk++;
        if (log_pos[2] !== 8'hC9 || log_val[2] !== 8'h81) begin
            n_fail++; $display("FAIL order_last: got %h/%h expected C9/81", log_pos[2], log_val[2]);
        end
        wait_idle(100);
        n_chk++; if (log_pos.size() != 3) begin n_fail++; $display("FAIL order_count: got %0d expected 3", log_pos.size()); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h6D;
        tick();
        wr_en = 1'b0;
        tick();
        wr_en = 1'b1; wr_data = 8'h7D;
        tick();
        wr_en = 1'b0;
        wait_pulses(2, 100, "race");
        n_chk++;
        if (log_pos[0] !== 8'hC5 || log_val[0] !== 8'h6D) begin
            n_fail++; $display("FAIL race_first: got %h/%h expected C5/6D", log_pos[0], log_val[0]);
        end
        n_chk++;
        if (log_pos[1] !== 8'hC5 || log_val[1] !== 8'h7D) begin
            n_fail++; $display("FAIL race_second: got %h/%h expected C5/7D", log_pos[1], log_val[1]);
        end
        wait_idle(100);
        n_chk++; if (log_pos.size() != 2) begin n_fail++; $display("FAIL race_count: got %0d expected 2", log_pos.size()); end
    endtask

    task automatic test_timeout();
        int k = 0;
        int cp;
        wmode = 0;
        clear_log();
        wr_en = 1'b1; wr_addr = 4'hA; wr_data = 8'h11;
        tick();
        wr_en = 1'b0;
        wait_pulses(1, 10, "to_first");
        cp = log_cyc[0];
        while (err !== 1'b1 && k < 100) begin tick(); k++; end
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %0b expected 1", err); end
        n_chk++; if (cyc - cp != 64) begin n_fail++; $display("FAIL to_delay: got %0d expected 64", cyc - cp); end
        wait_pulses(2, 10, "to_retry");
        n_chk++;
        if (log_pos[1] !== 8'hCA || log_val[1] !== 8'h11 || log_cyc[1] - cp != 66) begin
            n_fail++; $display("FAIL to_retry: got %h/%h at +%0d expected CA/11 at +66", log_pos[1], log_val[1], log_cyc[1] - cp);
        end
        wmode = 1;
        wait_pulses(3, 100, "to_accept");
        repeat (3) tick();
        RSTN = 1'b0;
        tick();
        n_chk++; if (wp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %0b expected 0", wp_valid); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err: got %0b expected 0", err); end
        clear_log();
        RSTN = 1'b1;
        wait_pulses(17, TB_GAP + 1000, "rerun");
        n_chk++;
        if (log_pos[0] !== 8'hFF || log_val[0] !== 8'h8F) begin
            n_fail++; $display("FAIL rerun_ctrl: got %h/%h expected FF/8F", log_pos[0], log_val[0]);
        end
        n_chk++;
        if (log_pos[11] !== 8'hCA || log_val[11] !== 8'h00) begin
            n_fail++; $display("FAIL rerun_cleared: got %h/%h expected CA/00", log_pos[11], log_val[11]);
        end
        wait_idle(100);
        n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rerun_idle: got %0b expected 1", idle); end
    endtask

`ifdef AUTO_REFRESH_EN
    task automatic test_refresh();
        clear_log();
        wait_pulses(34, 4500, "refresh");
        n_chk++;
        if (log_pos[0] !== 8'hFF || log_val[0] !== 8'h89 || log_pos[17] !== 8'hFF || log_val[17] !== 8'h89) begin
            n_fail++; $display("FAIL refresh_ctrl: got %h/%h %h/%h expected FF/89 FF/89", log_pos[0], log_val[0], log_pos[17], log_val[17]);
        end
        n_chk++;
        if (log_pos[16] !== 8'hCF || log_pos[33] !== 8'hCF) begin
            n_fail++; $display("FAIL refresh_last: got %h %h expected CF CF", log_pos[16], log_pos[33]);
        end
        n_chk++;
        if (log_cyc[17] - log_cyc[0] < 1990 || log_cyc[17] - log_cyc[0] > 2010) begin
            n_fail++; $display("FAIL refresh_period: got %0d expected about 2000", log_cyc[17] - log_cyc[0]);
        end
    endtask
`else
    task automatic test_no_refresh();
        clear_log();
        repeat (10000) tick();
        n_chk++; if (log_pos.size() != 0) begin n_fail++; $display("FAIL quiet_pulses: got %0d expected 0", log_pos.size()); end
        n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL quiet_idle: got %0b expected 1", idle); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef AUTO_REFRESH_EN
        test_refresh();
`else
        test_single_write();
        test_order_ctrl();
        test_back_to_back();
        test_timeout();
        test_no_refresh();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
